// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB master controller.
//   - apb_state_e  : FSM state encoding (also exported on the debug port)
//   - DEC_*        : address bits that carry the completer index
//   - RESP_*       : completer response values as seen on PSLVERR / err_flag
package apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_DECERR = 3'd4
  } apb_state_e;

  localparam int DEC_LSB = 12;
  localparam int DEC_MSB = 15;
  localparam int DEC_W   = DEC_MSB - DEC_LSB + 1;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: combinational completer decode.
//   addr    in  : transfer address
//   idx     out : completer index taken from addr[DEC_MSB:DEC_LSB]
//   sel     out : one-hot select, all zero when the index is out of range
//   dec_err out : index does not name an existing completer
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DEC_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  dec_err
);

  always_comb begin
    idx     = addr[DEC_MSB:DEC_LSB];
    dec_err = (int'(idx) >= NUM_SLAVES);
    sel     = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!dec_err && (idx == DEC_W'(i))) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-outstanding APB master.
//
// Ports
//   ACLK, ARESET              clock, synchronous active-high reset
//   transfer/read/write       request strobe and qualifiers (write wins)
//   apb_waddr/apb_raddr       request addresses, held stable while busy
//   apb_wdata/apb_strb        write payload
//   apb_rdata/err_flag        result, held until the next accepted request
//   apb_done/busy             one-cycle completion pulse / not idle
//   PADDR..PENABLE            APB requester outputs (all registered)
//   PRDATA/PREADY/PSLVERR     flattened per-completer responses
//   dbg_state                 current FSM state
//
// Handshake: a request is accepted only when the FSM is IDLE and the
// cycle has transfer=1 with read or write set; anything else on
// transfer is dropped. A completer ends its access phase by asserting
// its own PREADY bit while PSEL and PENABLE are both high; bits of
// completers that are not selected are never looked at.
//
// Every output flop is loaded from the value the next state calls for,
// so a request seen in cycle N gives PSEL in N+1, PENABLE in N+2 and,
// for a zero-wait completer, apb_done in N+3.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic                             transfer,
  input  logic                             read,
  input  logic                             write,
  input  logic [ADDR_WIDTH-1:0]            apb_waddr,
  input  logic [ADDR_WIDTH-1:0]            apb_raddr,
  input  logic [DATA_WIDTH-1:0]            apb_wdata,
  input  logic [3:0]                       apb_strb,
  output logic [DATA_WIDTH-1:0]            apb_rdata,
  output logic                             err_flag,
  output logic                             apb_done,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [3:0]                       PSTRB,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR,
  output apb_state_e                       dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  apb_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [DEC_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err;
  logic                  ready_sel;
  logic                  slverr_sel;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic                  timeout_hit;

  assign accept = (state_q == ST_IDLE) && transfer && (read || write);

  // In IDLE decode the incoming request; afterwards decode the held PADDR.
  assign dec_addr = (state_q == ST_IDLE) ? (write ? apb_waddr : apb_raddr) : paddr_q;

  apb_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_dec (
    .addr    (dec_addr),
    .idx     (dec_idx),
    .sel     (dec_sel),
    .dec_err (dec_err)
  );

  // Masking with PSEL keeps other completers' ready/error bits out.
  assign ready_sel   = |(PREADY & psel_q);
  assign slverr_sel  = |(PSLVERR & psel_q);
  assign timeout_hit = (int'(cnt_q) + 1 >= TIMEOUT_CYCLES);

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dec_idx == DEC_W'(i)) rdata_sel = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = dec_err ? ST_DECERR : ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (ready_sel || timeout_hit) state_d = ST_DONE;
      ST_DECERR: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: values the output flops take on the coming edge
  always_comb begin
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d = RESP_OKAY;
          if (write) begin
            paddr_d  = apb_waddr;
            pwrite_d = 1'b1;
            pwdata_d = apb_wdata;
            pstrb_d  = apb_strb;
          end else begin
            paddr_d  = apb_raddr;
            pwrite_d = 1'b0;
            pstrb_d  = 4'h0;
          end
        end
      end
      ST_ACCESS: begin
        if (ready_sel) begin
          err_d = slverr_sel ? RESP_SLVERR : RESP_OKAY;
          if (!pwrite_q) rdata_d = rdata_sel;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout_hit) begin
            err_d = RESP_SLVERR;
            if (!pwrite_q) rdata_d = '0;
          end
        end
      end
      default: ;
    endcase

    if (state_d == ST_DECERR) begin
      err_d = RESP_SLVERR;
      if (!pwrite_d) rdata_d = '0;
    end

    if (state_d == ST_SETUP) cnt_d = '0;

    psel_d    = ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) ? dec_sel : '0;
    penable_d = (state_d == ST_ACCESS);
    done_d    = (state_d == ST_DONE);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= 4'h0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign apb_rdata = rdata_q;
  assign err_flag  = err_q;
  assign apb_done  = done_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;
  import apb_pkg::*;

  localparam int NS  = 4;
  localparam int TMO = 16;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          waits;   // access cycles with PREADY low; -1 = never ready
    bit          slverr;
    logic [31:0] rdv;
  } stim_t;

  typedef struct {
    int          done_c;  // cycle of apb_done after the request cycle, -1 = none
    int          pen_c;
    logic [3:0]  psel;    // OR of every PSEL value seen
    int          pulses;
    bit          err;
    logic [31:0] rdata;
    bit          err_c1;  // err_flag one cycle after the request
  } exp_t;

  typedef struct {
    exp_t o;
    bit   fields_ok;
    bit   stable;
    bit   done_clean;
  } res_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          transfer, read, write;
  logic [31:0]   apb_waddr, apb_raddr, apb_wdata;
  logic [3:0]    apb_strb;
  logic [31:0]   apb_rdata;
  logic          err_flag, apb_done, busy;
  logic [31:0]   PADDR;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [3:0]    PSTRB;
  logic [NS-1:0] PSEL;
  logic          PENABLE;
  logic [NS*32-1:0] PRDATA;
  logic [NS-1:0] PREADY, PSLVERR;
  apb_state_e    dbg_state;

  always #5 ACLK = ~ACLK;

  apb_master_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .transfer(transfer), .read(read), .write(write),
    .apb_waddr(apb_waddr), .apb_raddr(apb_raddr), .apb_wdata(apb_wdata),
    .apb_strb(apb_strb), .apb_rdata(apb_rdata), .err_flag(err_flag),
    .apb_done(apb_done), .busy(busy), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  bit   mdl_err;
  logic [31:0] mdl_rdata;

  function automatic void chk(string tag, string what, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
    end
  endfunction

  function automatic vec_t mk(bit wr, bit rd, logic [31:0] addr, logic [31:0] data,
                              logic [3:0] strb, int waits, bit slverr, logic [31:0] rdv,
                              int done_c, int pen_c, logic [3:0] psel, int pulses,
                              bit err, logic [31:0] rdata, bit err_c1);
    vec_t v;
    v.s = '{wr, rd, addr, data, strb, waits, slverr, rdv};
    v.e = '{done_c, pen_c, psel, pulses, err, rdata, err_c1};
    return v;
  endfunction

  // Reference model: outcome of one request from the protocol rules.
  task automatic ref_model(input stim_t s, output exp_t e);
    int idx;
    idx = int'(s.addr[15:12]);
    e.pulses = 1;
    if (!s.wr && !s.rd) begin
      e = '{-1, -1, 4'h0, 0, mdl_err, mdl_rdata, mdl_err};
    end else if (idx >= NS) begin
      e.done_c = 2; e.pen_c = -1; e.psel = 4'h0; e.err_c1 = 1'b1;
      mdl_err = 1'b1;
      if (!s.wr) mdl_rdata = 32'h0;
    end else begin
      e.psel = 4'h1 << idx; e.pen_c = 2; e.err_c1 = 1'b0;
      if (s.waits < 0 || s.waits >= TMO) begin
        e.done_c = 2 + TMO;
        mdl_err = 1'b1;
        if (!s.wr) mdl_rdata = 32'h0;
      end else begin
        e.done_c = 3 + s.waits;
        mdl_err = s.slverr;
        if (!s.wr) mdl_rdata = s.rdv;
      end
    end
    e.err   = mdl_err;
    e.rdata = mdl_rdata;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1; transfer = 1'b0; PREADY = '0;
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  // Issues one request and plays the completer side until it finishes.
  task automatic run_xfer(input stim_t s, input bit noise, output res_t r);
    logic [3:0]  idx;
    int          acc;
    bit          first;
    logic [31:0] sa, sd;
    logic [3:0]  ss;
    logic        sp;
    idx = s.addr[15:12];
    acc = 0; first = 1'b1;
    sa = '0; sd = '0; ss = '0; sp = 1'b0;
    r.o = '{-1, -1, 4'h0, 0, 1'b0, 32'h0, 1'b0};
    r.fields_ok = 1'b1; r.stable = 1'b1; r.done_clean = 1'b1;
    @(negedge ACLK);
    transfer  = 1'b1;
    write     = s.wr;
    read      = s.rd;
    apb_waddr = s.wr ? s.addr : $urandom;
    apb_raddr = s.wr ? $urandom : s.addr;
    apb_wdata = s.data;
    apb_strb  = s.strb;
    PREADY    = '0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge ACLK);
      if (k == 1) r.o.err_c1 = err_flag;
      if (PSEL != '0) begin
        r.o.psel |= PSEL;
        if (first) begin
          first = 1'b0;
          sa = PADDR; sd = PWDATA; ss = PSTRB; sp = PWRITE;
          if (PADDR !== s.addr || PWRITE !== s.wr || PSTRB !== (s.wr ? s.strb : 4'h0) ||
              (s.wr && PWDATA !== s.data)) r.fields_ok = 1'b0;
        end else if (PADDR !== sa || PWDATA !== sd || PSTRB !== ss || PWRITE !== sp) begin
          r.stable = 1'b0;
        end
      end
      if (PENABLE && r.o.pen_c < 0) r.o.pen_c = k;
      if (apb_done) begin
        r.o.pulses++;
        if (r.o.done_c < 0) begin
          r.o.done_c = k;
          if (PSEL != '0 || PENABLE || !busy) r.done_clean = 1'b0;
        end
      end
      r.o.err   = err_flag;
      r.o.rdata = apb_rdata;
      transfer = (noise && busy && !apb_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      PREADY   = noise ? 4'($urandom) : 4'h0;
      PSLVERR  = 4'($urandom);
      PRDATA   = {$urandom, $urandom, $urandom, $urandom};
      if (idx < 4) begin
        PREADY[idx[1:0]] = 1'b0;
        if (PSEL[idx[1:0]] && PENABLE) begin
          acc++;
          if (s.waits >= 0 && acc > s.waits) begin
            PREADY[idx[1:0]]            = 1'b1;
            PSLVERR[idx[1:0]]           = s.slverr;
            PRDATA[idx[1:0]*32 +: 32]   = s.rdv;
          end
        end
      end
      if (r.o.done_c >= 0 && k >= r.o.done_c + 2) break;
    end
    transfer = 1'b0;
    PREADY   = '0;
  endtask

  task automatic compare(input string tag, input exp_t e, input res_t r);
    chk(tag, "done_cycle", 64'(r.o.done_c), 64'(e.done_c));
    chk(tag, "penable_cycle", 64'(r.o.pen_c), 64'(e.pen_c));
    chk(tag, "psel", 64'(r.o.psel), 64'(e.psel));
    chk(tag, "done_pulses", 64'(r.o.pulses), 64'(e.pulses));
    chk(tag, "err_flag", 64'(r.o.err), 64'(e.err));
    chk(tag, "apb_rdata", 64'(r.o.rdata), 64'(e.rdata));
    chk(tag, "err_after_accept", 64'(r.o.err_c1), 64'(e.err_c1));
    chk(tag, "apb_fields", 64'(r.fields_ok), 64'h1);
    chk(tag, "apb_stable", 64'(r.stable), 64'h1);
    chk(tag, "done_clean", 64'(r.done_clean), 64'h1);
  endtask

  // ---------------- test ----------------
  vec_t  tbl[13];
  stim_t st;
  res_t  res;
  exp_t  ex;
  int    pulses;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //      wr rd addr          data          strb  waits slv rdv          | done pen psel  pls err rdata        errc1
    tbl[0]  = mk(1, 0, 32'h0000_1004, 32'hDEADBEEF, 4'hF,  0, 0, 32'h0,        3,  2, 4'b0010, 1, 0, 32'h0,        0);
    tbl[1]  = mk(0, 1, 32'h0000_2000, 32'h0,        4'h0,  3, 0, 32'h12345678, 6,  2, 4'b0100, 1, 0, 32'h12345678, 0);
    tbl[2]  = mk(0, 1, 32'h0000_5000, 32'h0,        4'h0,  0, 0, 32'h0,        2, -1, 4'b0000, 1, 1, 32'h0,        1);
    tbl[3]  = mk(1, 0, 32'h0000_0010, 32'h11112222, 4'h3, -1, 0, 32'h0,       18,  2, 4'b0001, 1, 1, 32'h0,        0);
    tbl[4]  = mk(1, 0, 32'h0000_3000, 32'h55AA55AA, 4'hC,  1, 1, 32'h0,        4,  2, 4'b1000, 1, 1, 32'h0,        0);
    tbl[5]  = mk(0, 1, 32'h0000_3008, 32'h0,        4'h0,  0, 0, 32'hA5A50001, 3,  2, 4'b1000, 1, 0, 32'hA5A50001, 0);
    tbl[6]  = mk(1, 0, 32'h0000_2000, 32'h01020304, 4'h5, 15, 0, 32'h0,       18,  2, 4'b0100, 1, 0, 32'hA5A50001, 0);
    tbl[7]  = mk(0, 1, 32'h0000_1000, 32'h0,        4'h0, 16, 0, 32'h77777777,18,  2, 4'b0010, 1, 1, 32'h0,        0);
    tbl[8]  = mk(0, 1, 32'h0000_1000, 32'h0,        4'h0,  2, 0, 32'hCAFEF00D, 5,  2, 4'b0010, 1, 0, 32'hCAFEF00D, 0);
    tbl[9]  = mk(1, 0, 32'h0000_6000, 32'h99999999, 4'hF,  0, 0, 32'h0,        2, -1, 4'b0000, 1, 1, 32'hCAFEF00D, 1);
    tbl[10] = mk(1, 1, 32'h0000_1010, 32'h13579BDF, 4'h1,  0, 0, 32'h0,        3,  2, 4'b0010, 1, 0, 32'hCAFEF00D, 0);
    tbl[11] = mk(0, 0, 32'h0000_1000, 32'h0,        4'h0,  0, 0, 32'h0,       -1, -1, 4'b0000, 0, 0, 32'hCAFEF00D, 0);
    tbl[12] = mk(0, 1, 32'h0000_3000, 32'h0,        4'h0,  0, 1, 32'h0BADBAD0, 3,  2, 4'b1000, 1, 1, 32'h0BADBAD0, 0);

    ARESET = 1'b1; transfer = 1'b1; write = 1'b1; read = 1'b0;
    apb_waddr = 32'h1234_1000; apb_raddr = 32'h0; apb_wdata = 32'hFFFF_FFFF; apb_strb = 4'hF;
    PREADY = '0; PSLVERR = '0; PRDATA = '0;

    // Reset state, with a request held during reset.
    repeat (2) @(negedge ACLK);
    chk("reset", "outputs", {PSEL, PENABLE, PWRITE, PSTRB, apb_done, busy, err_flag}, 64'h0);
    chk("reset", "paddr_pwdata", {PADDR, PWDATA}, 64'h0);
    chk("reset", "apb_rdata", 64'(apb_rdata), 64'h0);
    chk("reset", "state", 64'(dbg_state), 64'(ST_IDLE));
    ARESET = 1'b0; transfer = 1'b0;
    @(negedge ACLK);
    chk("reset_xfer_ignored", "busy", 64'(busy), 64'h0);

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      run_xfer(tbl[i].s, 1'b1, res);
      compare($sformatf("vec%0d", i), tbl[i].e, res);
    end

    // Reset in the middle of an access phase.
    @(negedge ACLK);
    transfer = 1'b1; write = 1'b1; read = 1'b0;
    apb_waddr = 32'h0000_1000; apb_wdata = 32'h0F0F_0F0F; apb_strb = 4'hF; PREADY = '0;
    @(negedge ACLK);
    transfer = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("midreset", "access_before", {PSEL, PENABLE}, {4'b0010, 1'b1});
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    chk("midreset", "psel_penable_busy", {PSEL, PENABLE, busy, apb_done}, 64'h0);
    pulses = 0;
    repeat (20) begin
      @(negedge ACLK);
      if (apb_done) pulses++;
    end
    chk("midreset", "no_done", 64'(pulses), 64'h0);
    st = '{1'b1, 1'b0, 32'h0000_1008, 32'h600D_600D, 4'hF, 0, 1'b0, 32'h0};
    run_xfer(st, 1'b0, res);
    ex = '{3, 2, 4'b0010, 1, 1'b0, 32'h0, 1'b0};
    compare("after_reset", ex, res);

    // Randomized requests checked against the reference model.
    do_reset();
    mdl_err = 1'b0; mdl_rdata = 32'h0;
    for (int n = 0; n < 60; n++) begin
      int w;
      st.wr   = 1'($urandom_range(0, 1));
      st.rd   = 1'($urandom_range(0, 1));
      st.addr = $urandom;
      st.addr[15:12] = 4'($urandom_range(0, 7));
      st.data = $urandom;
      st.strb = 4'($urandom);
      w = $urandom_range(0, 9);
      st.waits  = (w <= 5) ? w : (w == 6) ? 15 : (w == 7) ? 16 : (w == 8) ? -1 : $urandom_range(0, 3);
      st.slverr = 1'($urandom_range(0, 1));
      st.rdv    = $urandom;
      ref_model(st, ex);
      exp_q.push_back(ex);
      run_xfer(st, 1'b1, res);
      compare($sformatf("rand%0d", n), exp_q.pop_front(), res);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
